// File: rtl/pkg_io.sv
// Shared types and constants for the ULM I/O execution unit and its UART.
package pkg_io;

    localparam int unsigned IO_RX_DEPTH = 4;

    typedef enum logic [1:0] {
        IO_NOP,
        IO_PUTC_IMM,
        IO_PUTC_REG,
        IO_GETC
    } io_op_t;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_WAIT_TX,
        CTL_WAIT_RX
    } io_ctl_state_t;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/if_instr_io.sv
// Decoded I/O instruction bundle passed from the decoder to the I/O unit.
interface if_instr_io;
    import pkg_io::*;

    io_op_t     op;
    logic [7:0] char_imm;
    logic [3:0] char_reg;

    modport server (input op, char_imm, char_reg);
    modport client (output op, char_imm, char_reg);
endinterface

// File: rtl/dev_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, 8N1 framing.
module dev_uart_rx
    import pkg_io::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ferr_q, ferr_d;

    assign rx_s         = sync_q[1];
    assign rx_byte      = shift_q;
    assign rx_frame_err = ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        rx_valid = 1'b0;
        case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) state_d = UART_START;
            end
            UART_START: begin
                // Half-bit recheck rejects glitches shorter than half a bit.
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = UART_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            UART_STOP: begin
                if (cnt_q == CntLast) begin
                    state_d  = UART_IDLE;
                    rx_valid = rx_s;
                    ferr_d   = !rx_s;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/dev_io_uart.sv
// I/O execution unit for putc/getc: UART TX, RX buffer and control FSM.
// Define IO_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module dev_io_uart
    import pkg_io::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    if_instr_io.server       instr_io,
    output logic [3:0]       reg_raddr,
    input  logic [63:0]      reg_rdata,
    output logic             reg_we,
    output logic [3:0]       reg_waddr,
    output logic [63:0]      reg_wdata,
    output logic             busy,
    output logic             done,
    output logic             tx,
    input  logic             rx,
    output logic             rx_overrun,
    output logic             rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);

    io_ctl_state_t ctl_q, ctl_d;
    logic [7:0]    char_q, char_d;
    logic [3:0]    waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          overrun_q;

    logic          accept, tx_idle, tx_load;
    logic [7:0]    tx_load_byte;
    logic          pop, bypass, push, push_ok, rx_full, rx_avail;
    logic [7:0]    rx_head;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          unused_rdata;

    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;

    assign unused_rdata = ^reg_rdata[63:8];
    assign reg_raddr    = instr_io.char_reg;
    assign reg_we       = we_q;
    assign reg_waddr    = waddr_q;
    assign reg_wdata    = {56'b0, wdata_q};
    assign busy         = (ctl_q != CTL_IDLE);
    assign done         = done_q;
    assign rx_overrun   = overrun_q;
    assign accept       = en && (ctl_q == CTL_IDLE) && (instr_io.op != IO_NOP);
    assign tx_idle      = (tx_state_q == UART_IDLE);

    dev_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q   <= CTL_IDLE;
            char_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            char_q  <= char_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ctl_d        = ctl_q;
        char_d       = char_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        done_d       = 1'b0;
        tx_load      = 1'b0;
        tx_load_byte = char_q;
        pop          = 1'b0;
        bypass       = 1'b0;
        case (ctl_q)
            CTL_IDLE: begin
                if (accept) begin
                    unique case (instr_io.op)
                        IO_PUTC_IMM, IO_PUTC_REG: begin
                            char_d = (instr_io.op == IO_PUTC_IMM) ? instr_io.char_imm
                                                                  : reg_rdata[7:0];
                            if (tx_idle) begin
                                tx_load      = 1'b1;
                                tx_load_byte = char_d;
                                done_d       = 1'b1;
                            end else begin
                                ctl_d = CTL_WAIT_TX;
                            end
                        end
                        IO_GETC: begin
                            waddr_d = instr_io.char_reg;
                            if (rx_avail) begin
                                pop     = 1'b1;
                                we_d    = 1'b1;
                                wdata_d = rx_head;
                                done_d  = 1'b1;
                            end else begin
                                ctl_d = CTL_WAIT_RX;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CTL_WAIT_TX: begin
                if (tx_idle) begin
                    tx_load = 1'b1;
                    done_d  = 1'b1;
                    ctl_d   = CTL_IDLE;
                end
            end
            CTL_WAIT_RX: begin
                // A byte completing while we wait goes straight to the register file.
                if (rx_avail) begin
                    pop     = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = rx_head;
                    done_d  = 1'b1;
                    ctl_d   = CTL_IDLE;
                end else if (rx_valid) begin
                    bypass  = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = rx_byte;
                    done_d  = 1'b1;
                    ctl_d   = CTL_IDLE;
                end
            end
            default: ctl_d = CTL_IDLE;
        endcase
    end

    // RX buffer
    assign push    = rx_valid && !bypass;
    assign push_ok = push && (!rx_full || pop);

`ifdef IO_RX_FIFO_EN
    logic [7:0] mem_q [IO_RX_DEPTH];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] rx_cnt_q;

    assign rx_full  = (rx_cnt_q == 3'(IO_RX_DEPTH));
    assign rx_avail = (rx_cnt_q != 3'd0);
    assign rx_head  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 2'd1;
            if (pop)     rptr_q <= rptr_q + 2'd1;
            rx_cnt_q <= rx_cnt_q + {2'b0, push_ok} - {2'b0, pop};
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    assign rx_full  = hold_vld_q;
    assign rx_avail = hold_vld_q;
    assign rx_head  = hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            if (push_ok) hold_q <= rx_byte;
            hold_vld_q <= push_ok || (hold_vld_q && !pop);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_q || (push && !push_ok);
    end

    // TX FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx         = 1'b1;
        case (tx_state_q)
            UART_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_state_d = UART_START;
                    tx_shift_d = tx_load_byte;
                end
            end
            UART_START: begin
                tx = 1'b0;
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                tx = tx_shift_q[0];
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            UART_STOP: begin
                if (tx_cnt_q == CntLast) tx_state_d = UART_IDLE;
            end
            default: tx_state_d = UART_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dev_io_uart.sv
// Directed bench for dev_io_uart with TX/RX scoreboards, CLKS_PER_BIT = 4.
module tb_dev_io_uart;
    import pkg_io::*;

    localparam int unsigned CPB = 4;
`ifdef IO_RX_FIFO_EN
    localparam int KEEP = 4;
`else
    localparam int KEEP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, en, rx;
    logic [63:0] reg_rdata;
    logic [3:0]  reg_raddr, reg_waddr;
    logic        reg_we, busy, done, tx, rx_overrun, rx_frame_err;
    logic [63:0] reg_wdata;
    logic [63:0] regs [16];

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  tx_exp_q [$];
    logic [7:0]  rx_exp_q [$];
    bit          mon_en;
    bit          sending;
    logic [7:0]  mon_b;
    logic        mon_stop;

    if_instr_io u_if ();

    always #5 clk = ~clk;
    assign reg_rdata = regs[reg_raddr];

    dev_io_uart #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .instr_io     (u_if),
        .reg_raddr    (reg_raddr),
        .reg_rdata    (reg_rdata),
        .reg_we       (reg_we),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .busy         (busy),
        .done         (done),
        .tx           (tx),
        .rx           (rx),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input io_op_t op, input logic [7:0] imm, input logic [3:0] r);
        u_if.op       = op;
        u_if.char_imm = imm;
        u_if.char_reg = r;
        en            = 1'b1;
        cyc(1);
        en            = 1'b0;
        u_if.op       = IO_NOP;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        sending = 1'b1;
        rx      = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop;
        cyc(CPB);
        rx = 1'b1;
        cyc(1);
        sending = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        while (sending && n < 200) begin
            cyc(1);
            n++;
        end
        check("rx_send_finished", 64'(sending), 64'd0);
    endtask

    task automatic wait_tx_drained();
        int n = 0;
        while (tx_exp_q.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        check("tx_sb_drained", 64'(tx_exp_q.size()), 64'd0);
    endtask

    task automatic expect_we(input int budget, input bit chk_busy, input logic [3:0] addr,
                             output int lat);
        int n = 0;
        while (!reg_we && n < budget) begin
            if (chk_busy) check("busy_while_waiting", 64'(busy), 64'd1);
            cyc(1);
            n++;
        end
        lat = n;
        check("reg_we", 64'(reg_we), 64'd1);
        if (reg_we) begin
            check("reg_waddr", 64'(reg_waddr), 64'(addr));
            check("getc_done", 64'(done), 64'd1);
            if (rx_exp_q.size() > 0) begin
                check("reg_wdata", reg_wdata, {56'b0, rx_exp_q.pop_front()});
            end else begin
                n_cmp++;
                n_fail++;
                $error("FAIL rx_sb_empty: observed %0h expected none", reg_wdata);
            end
        end
    endtask

    // TX line monitor: decodes frames mid-bit and compares with the TX scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                cyc(6);
                mon_b[0] = tx;
                for (int k = 1; k < 8; k++) begin
                    cyc(CPB);
                    mon_b[k] = tx;
                end
                cyc(CPB);
                mon_stop = tx;
                check("tx_stop_bit", 64'(mon_stop), 64'd1);
                if (tx_exp_q.size() > 0) begin
                    check("tx_frame_byte", 64'(mon_b), 64'(tx_exp_q.pop_front()));
                end else begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL tx_unexpected_frame: observed %0h expected none", mon_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         lat;
        int         n;
        bit         saw_done, saw_low;
        logic [7:0] ch;
        logic       exp_bit;

        rst = 1'b1;
        en = 1'b0;
        rx = 1'b1;
        u_if.op = IO_NOP;
        u_if.char_imm = '0;
        u_if.char_reg = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        regs[3] = 64'h142;
        mon_en = 1'b1;
        sending = 1'b0;
        cyc(3);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_reg_we", 64'(reg_we), 64'd0);
        check("rst_reg_wdata", reg_wdata, 64'd0);
        check("rst_overrun", 64'(rx_overrun), 64'd0);
        check("rst_frame_err", 64'(rx_frame_err), 64'd0);
        rst = 1'b0;
        cyc(2);

        // putc imm with idle transmitter: cycle-exact frame check
        ch = 8'h41;
        tx_exp_q.push_back(ch);
        issue(IO_PUTC_IMM, ch, 4'd0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_bit = 1'b0;
            else if (i < 36) exp_bit = ch[(i - 4) / 4];
            else             exp_bit = 1'b1;
            check("t1_tx_bit", 64'(tx), 64'(exp_bit));
            if (i == 1)  check("t1_done_pulse", 64'(done), 64'd0);
            if (i == 20) check("t1_busy_mid", 64'(busy), 64'd0);
            cyc(1);
        end
        check("t1_tx_idle", 64'(tx), 64'd1);

        // Back-to-back putc: second waits for the first frame (40 cycles + 1 idle cycle)
        cyc(2);
        tx_exp_q.push_back(8'h41);
        issue(IO_PUTC_IMM, 8'h41, 4'd0);
        cyc(1);
        tx_exp_q.push_back(8'h42);
        issue(IO_PUTC_REG, 8'h00, 4'd3);
        n = 0;
        while (!done && n < 100) begin
            check("t2_busy", 64'(busy), 64'd1);
            cyc(1);
            n++;
        end
        check("t2_done_latency", 64'(n), 64'd39);
        check("t2_busy_drop", 64'(busy), 64'd0);
        wait_tx_drained();

        // getc with a byte already buffered
        rx_exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        cyc(4);
        issue(IO_GETC, 8'h00, 4'd7);
        expect_we(0, 1'b0, 4'd7, lat);
        cyc(1);
        check("t3_we_pulse", 64'(reg_we), 64'd0);
        check("t3_done_pulse", 64'(done), 64'd0);

        // Blocking getc
        issue(IO_GETC, 8'h00, 4'd2);
        check("t4_busy_start", 64'(busy), 64'd1);
        for (int i = 0; i < 50; i++) begin
            check("t4_busy_hold", 64'(busy), 64'd1);
            cyc(1);
        end
        rx_exp_q.push_back(8'h0D);
        fork
            send_rx(8'h0D, 1'b1);
        join_none
        expect_we(100, 1'b1, 4'd2, lat);
        // 2 sync flops + 9.5 bits to the stop sample + 1 cycle to reg_we
        check("t4_latency_window", 64'(lat >= 39 && lat <= 43), 64'd1);
        wait_send();

        // Overrun: five bytes, no getc
        check("t5_overrun_before", 64'(rx_overrun), 64'd0);
        for (int v = 1; v <= 5; v++) begin
            if (v <= KEEP) rx_exp_q.push_back(8'(v));
            send_rx(8'(v), 1'b1);
            cyc(1);
        end
        cyc(4);
        check("t5_overrun", 64'(rx_overrun), 64'd1);
        for (int i = 0; i < KEEP; i++) begin
            issue(IO_GETC, 8'h00, 4'(i + 4));
            expect_we(0, 1'b0, 4'(i + 4), lat);
            cyc(1);
        end

        // Glitch, then bad stop bit, then a good byte completes a waiting getc
        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(20);
        issue(IO_GETC, 8'h00, 4'd9);
        cyc(3);
        check("t6_glitch_no_push", 64'(busy), 64'd1);
        fork
            send_rx(8'hAA, 1'b0);
        join_none
        n = 0;
        while (!rx_frame_err && n < 100) begin
            cyc(1);
            n++;
        end
        check("t6_frame_err", 64'(rx_frame_err), 64'd1);
        check("t6_ferr_no_we", 64'(reg_we), 64'd0);
        cyc(1);
        check("t6_frame_err_pulse", 64'(rx_frame_err), 64'd0);
        wait_send();
        cyc(2);
        check("t6_ferr_no_push", 64'(busy), 64'd1);
        rx_exp_q.push_back(8'h77);
        fork
            send_rx(8'h77, 1'b1);
        join_none
        expect_we(100, 1'b1, 4'd9, lat);
        wait_send();

        // Reset in the middle of a frame with a second putc pending
        wait_tx_drained();
        mon_en = 1'b0;
        cyc(2);
        issue(IO_PUTC_IMM, 8'h00, 4'd0);
        cyc(1);
        issue(IO_PUTC_IMM, 8'h55, 4'd0);
        check("t7_busy_pending", 64'(busy), 64'd1);
        cyc(10);
        check("t7_tx_mid_frame", 64'(tx), 64'd0);
        rst = 1'b1;
        cyc(1);
        check("t7_tx_after_rst", 64'(tx), 64'd1);
        check("t7_busy_after_rst", 64'(busy), 64'd0);
        check("t7_overrun_cleared", 64'(rx_overrun), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (done) saw_done = 1'b1;
            if (!tx)  saw_low = 1'b1;
        end
        check("t7_no_done", 64'(saw_done), 64'd0);
        check("t7_tx_stays_idle", 64'(saw_low), 64'd0);

        check("rx_sb_empty_end", 64'(rx_exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
